// File: rtl/spi_master_mcs.sv
// Multi-slave SPI master with a per-frame configuration that is latched when
// the frame is accepted: CPOL/CPHA, frame length, bit order, SCK divider,
// slave select and CS hold for back-to-back bursts.
module spi_master_mcs #(
   parameter int DATA_WIDTH_LOG = 5,
   parameter int CS_NUM         = 4,
   parameter int DIV_WIDTH      = 8,
   localparam int W             = 2**DATA_WIDTH_LOG,
   // one spare bit so out-of-range selects can be presented and flagged
   localparam int SEL_W         = $clog2(CS_NUM) + 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      cfg_cpol,
   input  logic                      cfg_cpha,
   input  logic [DATA_WIDTH_LOG-1:0] cfg_len,
   input  logic                      cfg_lsb_first,
   input  logic [DIV_WIDTH-1:0]      cfg_div,
   input  logic [SEL_W-1:0]          cfg_cs_sel,
   input  logic                      cfg_cs_keep,
   input  logic [W-1:0]              din,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   output logic [W-1:0]              dout,
   output logic                      sck,
   output logic [CS_NUM-1:0]         cs_n,
   output logic                      mosi,
   input  logic                      miso
);

   localparam int DL = DATA_WIDTH_LOG;

   typedef enum logic [2:0] {IDLE, GAP, SETUP, XFER, HOLD} state_t;

   state_t               state_q, state_d;
   logic [DIV_WIDTH-1:0] hcnt_q;     // cycles left in current half-period
   logic [DL:0]          ecnt_q;     // SCK edge index within the frame, 0..2N-1
   logic [W-1:0]         din_q, rx_q;
   logic [DL-1:0]        len_q;
   logic [DIV_WIDTH-1:0] div_q;
   logic                 cpol_q, cpha_q, lsb_q, keep_q, held_q;
   logic [SEL_W-1:0]     sel_q;

   // bit position inside the word for the b-th bit on the wire
   function automatic logic [DL-1:0] bit_pos(input logic lsb, input logic [DL-1:0] len,
                                             input logic [DL-1:0] b);
      return lsb ? b : len - b;
   endfunction

   logic          sel_ok, tick, lead, last_edge;
   logic [DL-1:0] bit_idx;
   assign sel_ok    = int'(cfg_cs_sel) < CS_NUM;
   assign tick      = (hcnt_q == '0);
   assign lead      = ~ecnt_q[0];
   assign last_edge = (ecnt_q == {len_q, 1'b1});
   assign bit_idx   = ecnt_q[DL:1];

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // next state: a held CS is reused only when slave and idle level both match
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (start && sel_ok) begin
            if (!held_q)                                     state_d = SETUP;
            else if (cfg_cs_sel == sel_q && cfg_cpol == sck) state_d = XFER;
            else                                             state_d = GAP;
         end
         GAP:     if (tick) state_d = SETUP;
         SETUP:   if (tick) state_d = XFER;
         XFER:    if (tick && last_edge) state_d = HOLD;
         HOLD:    if (tick) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // control strobes; in IDLE the frame view comes straight from the inputs
   logic                 accept, reject, enter, enter_gap, sel_low, edge_now;
   logic                 sample_now, shift_now, finish, first_bit;
   logic [DL-1:0]        shift_idx, f_len;
   logic [W-1:0]         f_din;
   logic [DIV_WIDTH-1:0] f_div;
   logic [SEL_W-1:0]     f_sel;
   logic                 f_cpol, f_cpha, f_lsb;
   always_comb begin
      accept     = (state_q == IDLE) && start && sel_ok;
      reject     = (state_q == IDLE) && start && !sel_ok;
      enter      = (state_d != state_q);
      enter_gap  = enter && (state_d == GAP);
      sel_low    = enter && (state_d == SETUP || (state_q == IDLE && state_d == XFER));
      edge_now   = (state_q == XFER) && tick;
      sample_now = edge_now && (cpha_q ? !lead : lead);
      shift_now  = edge_now && (cpha_q ? lead : (!lead && !last_edge));
      shift_idx  = cpha_q ? bit_idx : bit_idx + DL'(1);
      finish     = (state_q == HOLD) && tick;
      f_din      = (state_q == IDLE) ? din           : din_q;
      f_len      = (state_q == IDLE) ? cfg_len       : len_q;
      f_div      = (state_q == IDLE) ? cfg_div       : div_q;
      f_sel      = (state_q == IDLE) ? cfg_cs_sel    : sel_q;
      f_cpol     = (state_q == IDLE) ? cfg_cpol      : cpol_q;
      f_cpha     = (state_q == IDLE) ? cfg_cpha      : cpha_q;
      f_lsb      = (state_q == IDLE) ? cfg_lsb_first : lsb_q;
      first_bit  = f_din[bit_pos(f_lsb, f_len, '0)];
   end

   // datapath and registered pins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt_q <= '0;  ecnt_q <= '0;  din_q <= '0;  rx_q <= '0;
         len_q  <= '0;  div_q  <= '0;  sel_q <= '0;
         cpol_q <= 1'b0; cpha_q <= 1'b0; lsb_q <= 1'b0; keep_q <= 1'b0; held_q <= 1'b0;
         busy <= 1'b0; done <= 1'b0; err <= 1'b0; dout <= '0;
         sck  <= 1'b0; cs_n <= '1;   mosi <= 1'b0;
      end else begin
         done <= finish;
         err  <= reject;
         busy <= (state_d != IDLE);

         if (accept) begin
            din_q  <= din;      len_q  <= cfg_len;  div_q <= cfg_div;  sel_q <= cfg_cs_sel;
            cpol_q <= cfg_cpol; cpha_q <= cfg_cpha; lsb_q <= cfg_lsb_first;
            keep_q <= cfg_cs_keep;
            rx_q   <= '0;
            ecnt_q <= '0;
         end

         // half-period timer: reload on every state change and every SCK edge
         if (enter)                hcnt_q <= f_div;
         else if (edge_now)        hcnt_q <= div_q;
         else if (state_q != IDLE) hcnt_q <= hcnt_q - DIV_WIDTH'(1);

         if (edge_now && !last_edge) ecnt_q <= ecnt_q + (DL+1)'(1);

         if (sel_low)       sck <= f_cpol;
         else if (edge_now) sck <= ~sck;

         if (enter_gap)                cs_n <= '1;
         else if (sel_low)             cs_n <= ~(CS_NUM'(1) << f_sel);
         else if (finish && !keep_q)   cs_n <= '1;

         if (sel_low && !f_cpha) mosi <= first_bit;
         else if (shift_now)     mosi <= din_q[bit_pos(lsb_q, len_q, shift_idx)];

         if (sample_now) rx_q[bit_pos(lsb_q, len_q, bit_idx)] <= miso;

         if (finish) begin
            dout   <= rx_q;
            held_q <= keep_q;
         end
      end
   end

endmodule
